// File: rtl/adpll_pkg.sv
// Shared types and helpers for the ADPLL loop controller: state encoding,
// accumulator width derivation and saturating arithmetic.
package adpll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_TRACK    = 2'd2,
    ST_HOLDOVER = 2'd3
  } state_e;

  // Integrator width: control-word bits, fractional bits, sign and headroom.
  function automatic int acc_width(input int cc_width, input int acc_frac);
    return cc_width + acc_frac + 2;
  endfunction

  function automatic int sat_add(input int a, input int b, input int lim);
    longint s;
    s = longint'(a) + longint'(b);
    if (s > longint'(lim)) return lim;
    if (s < -longint'(lim)) return -lim;
    return int'(s);
  endfunction

  function automatic int clamp_range(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/adpll_lock_detect.sv
// Lock qualifier: exact |err| at ERR_WIDTH+1 bits, tolerance compares and a
// saturating count of consecutive in-tolerance samples.
module adpll_lock_detect #(
  parameter int ERR_WIDTH  = 8,
  parameter int LOCK_TOL   = 2,
  parameter int LOCK_COUNT = 16,
  parameter int UNLOCK_TOL = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 sample_i,
  input  logic                 clear_i,
  input  logic [ERR_WIDTH-1:0] err_i,
  output logic                 lock_reached_o,
  output logic                 unlock_hit_o
);

  localparam int CNT_W = $clog2(LOCK_COUNT + 1);

  logic signed [ERR_WIDTH:0] err_ext;
  logic        [ERR_WIDTH:0] err_mag;
  logic                      in_tol;
  logic        [CNT_W-1:0]   count_q;
  logic        [CNT_W-1:0]   count_d;

  always_comb begin
    err_ext = {err_i[ERR_WIDTH-1], err_i};
    err_mag = err_ext[ERR_WIDTH] ? unsigned'(-err_ext) : unsigned'(err_ext);
    in_tol  = int'(err_mag) <= LOCK_TOL;

    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (sample_i) begin
      if (!in_tol) count_d = '0;
      else if (int'(count_q) < LOCK_COUNT) count_d = count_q + 1'b1;
    end

    // Lock is declared on the sample that brings the count up to LOCK_COUNT.
    lock_reached_o = sample_i && in_tol && (int'(count_q) >= LOCK_COUNT - 1);
    unlock_hit_o   = sample_i && (int'(err_mag) > UNLOCK_TOL);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) count_q <= '0;
    else          count_q <= count_d;
  end

endmodule

// File: rtl/adpll_ctrl.sv
// ADPLL loop controller: gear-shifted PI filter wrapped in a lock/holdover FSM,
// driving a clamped unsigned ring-oscillator control word two cycles after a sample.
module adpll_ctrl
  import adpll_pkg::*;
#(
  parameter int ERR_WIDTH    = 8,
  parameter int CC_WIDTH     = 5,
  parameter int BIAS         = 16,
  parameter int ACC_FRAC     = 6,
  parameter int KP_SHIFT_ACQ = 0,
  parameter int KP_SHIFT_TRK = 1,
  parameter int KI_SHIFT_ACQ = 2,
  parameter int KI_SHIFT_TRK = 4,
  parameter int LOCK_TOL     = 2,
  parameter int LOCK_COUNT   = 16,
  parameter int UNLOCK_TOL   = 8
) (
  input  logic                        fpga_clk_i,
  input  logic                        reset_n_i,
  input  logic                        enable_i,
  input  logic                        err_valid_i,
  input  logic signed [ERR_WIDTH-1:0] err_i,
  input  logic                        ref_lost_i,
  output logic        [CC_WIDTH-1:0]  cc_o,
  output logic                        cc_valid_o,
  output logic                        locked_o,
  output logic        [1:0]           state_o
);

  localparam int ACC_W     = acc_width(CC_WIDTH, ACC_FRAC);
  localparam int INTEG_MAX = (1 << (CC_WIDTH + ACC_FRAC)) - 1;
  localparam int CC_MAX    = (1 << CC_WIDTH) - 1;

  state_e                    state_q, state_d;
  logic signed [ACC_W-1:0]   integ_q, integ_d;
  logic signed [31:0]        p_q, p_d;
  logic                      upd_q, upd_d;
  logic        [CC_WIDTH-1:0] cc_q, cc_d;
  logic                      cc_valid_q, cc_valid_d;
  logic                      locked_q, locked_d;

  logic sample_en;
  logic lock_clear;
  logic lock_reached;
  logic unlock_hit;
  int   e_val;
  int   kp_shift;
  int   ki_shift;
  int   ctl_val;

  adpll_lock_detect #(
    .ERR_WIDTH (ERR_WIDTH),
    .LOCK_TOL  (LOCK_TOL),
    .LOCK_COUNT(LOCK_COUNT),
    .UNLOCK_TOL(UNLOCK_TOL)
  ) u_lock_detect (
    .clk_i         (fpga_clk_i),
    .rst_n_i       (reset_n_i),
    .sample_i      (sample_en),
    .clear_i       (lock_clear),
    .err_i         (err_i),
    .lock_reached_o(lock_reached),
    .unlock_hit_o  (unlock_hit)
  );

  // Stage 1: FSM and integrator. The scaled error is held in a 32-bit int so
  // a full-scale sample cannot wrap before the integrator clamp sees it.
  always_comb begin
    state_d    = state_q;
    integ_d    = integ_q;
    p_d        = '0;
    upd_d      = 1'b0;
    sample_en  = 1'b0;
    e_val      = int'(err_i) <<< ACC_FRAC;
    kp_shift   = (state_q == ST_TRACK) ? KP_SHIFT_TRK : KP_SHIFT_ACQ;
    ki_shift   = (state_q == ST_TRACK) ? KI_SHIFT_TRK : KI_SHIFT_ACQ;

    if (!enable_i) begin
      state_d = ST_IDLE;
      integ_d = '0;
      upd_d   = (state_q != ST_IDLE);
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ACQUIRE;
          integ_d = '0;
        end
        ST_ACQUIRE, ST_TRACK: begin
          if (ref_lost_i) begin
            state_d = ST_HOLDOVER;
            upd_d   = 1'b1;
          end else if (err_valid_i) begin
            sample_en = 1'b1;
            upd_d     = 1'b1;
            p_d       = e_val >>> kp_shift;
            integ_d   = ACC_W'(sat_add(int'(integ_q), e_val >>> ki_shift, INTEG_MAX));
            if (state_q == ST_ACQUIRE && lock_reached) state_d = ST_TRACK;
            if (state_q == ST_TRACK && unlock_hit)     state_d = ST_ACQUIRE;
          end
        end
        ST_HOLDOVER: begin
          if (!ref_lost_i) state_d = ST_ACQUIRE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    lock_clear = (state_d != state_q) && (state_d != ST_TRACK);
    locked_d   = (state_d == ST_TRACK);
  end

  // Stage 2: output word; negative feedback around the free-running bias.
  always_comb begin
    ctl_val    = BIAS - ((int'(integ_q) + int'(p_q)) >>> ACC_FRAC);
    cc_valid_d = upd_q;
    cc_d       = upd_q ? CC_WIDTH'(clamp_range(ctl_val, 0, CC_MAX)) : cc_q;
  end

  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= ST_IDLE;
      integ_q    <= '0;
      p_q        <= '0;
      upd_q      <= 1'b0;
      cc_q       <= CC_WIDTH'(BIAS);
      cc_valid_q <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      integ_q    <= integ_d;
      p_q        <= p_d;
      upd_q      <= upd_d;
      cc_q       <= cc_d;
      cc_valid_q <= cc_valid_d;
      locked_q   <= locked_d;
    end
  end

  assign cc_o       = cc_q;
  assign cc_valid_o = cc_valid_q;
  assign locked_o   = locked_q;
  assign state_o    = state_q;

endmodule
